auth_session_ctrl: RTL and testbench

Front-end controller that sequences the card-authentication FSM from raw Basys push-buttons. It synchronizes and debounces the card (T) and PIN-valid (P) buttons and turns T presses into single-cycle step strobes. It monitors the FSM's A/E/F/state outputs, counts consecutive failed attempts and enforces a lockout. It also aborts a stalled session on inactivity by pulsing the FSM's reset.

---
 rtl/auth_pkg.sv | 19 +
 rtl/btn_debounce.sv | 49 ++++
 rtl/auth_session_ctrl.sv | 147 ++++++++++++++
 tb/tb_auth_session_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// rtl/auth_pkg.sv - shared controller / card-FSM state encodings and helpers
package auth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACTIVE  = 2'b01,
        LOCKOUT = 2'b10,
        ABORT   = 2'b11
    } ctrl_state_t;

    localparam logic [2:0] WAITS    = 3'b000;
    localparam logic [2:0] EJECTION = 3'b100;
    localparam logic [2:0] FAIL     = 3'b101;

    function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
        return (v >= lim) ? lim : v + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, stability debounce and rising-edge detect
module btn_debounce #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise
);

    logic        sync1_q, sync2_q;
    logic        clean_q, clean_d;
    logic        clean_prev_q;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            clean_q      <= 1'b0;
            clean_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            clean_q      <= clean_d;
            clean_prev_q <= clean_q;
            cnt_q        <= cnt_d;
        end
    end

    // Counter only runs while the synchronized level disagrees with the clean level.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = '0;
        if (sync2_q != clean_q) begin
            if (cnt_q == DEB_CYCLES - 16'd1) begin
                clean_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign clean = clean_q;
    assign rise  = clean_q & ~clean_prev_q;

endmodule

// File: rtl/auth_session_ctrl.sv
// rtl/auth_session_ctrl.sv - button front-end, failure lockout and inactivity abort for the card FSM
module auth_session_ctrl
    import auth_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES     = 16'd50000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
    parameter logic [2:0]  MAX_FAIL       = 3'd3,
    parameter logic [31:0] LOCK_CYCLES    = 32'd1_500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_t,
    input  logic       btn_p,
    input  logic       auth_a,
    input  logic       auth_e,
    input  logic       auth_f,
    input  logic [2:0] auth_state,
    output logic       t_step,
    output logic       p_lvl,
    output logic       auth_rst,
    output logic       locked,
    output logic [2:0] fail_cnt,
    output logic [1:0] ctrl_dbg
);

    ctrl_state_t state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  fail_cnt_q, fail_cnt_d;
    logic        f_prev_q, ae_prev_q;
    logic        t_step_q;
    logic        t_clean, t_rise, p_clean, p_rise;
    logic        fail_ev, succ_ev, lock_expire;
    logic        unused_ok;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_t (
        .clk(clk), .rst(rst), .raw(btn_t), .clean(t_clean), .rise(t_rise)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_p (
        .clk(clk), .rst(rst), .raw(btn_p), .clean(p_clean), .rise(p_rise)
    );

    assign unused_ok   = &{1'b0, t_clean, p_rise};
    assign fail_ev     = auth_f & ~f_prev_q;
    assign succ_ev     = (auth_a & auth_e) & ~ae_prev_q;
    assign lock_expire = (state_q == LOCKOUT) && (timer_q == LOCK_CYCLES - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q    <= '0;
            fail_cnt_q <= '0;
            f_prev_q   <= 1'b0;
            ae_prev_q  <= 1'b0;
            t_step_q   <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            fail_cnt_q <= fail_cnt_d;
            f_prev_q   <= auth_f;
            ae_prev_q  <= auth_a & auth_e;
            t_step_q   <= t_rise;
        end
    end

    // One timer serves both inactivity and lockout; it is zeroed on every state change.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            IDLE: begin
                if (auth_state != WAITS) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (fail_ev && (fail_cnt_q == MAX_FAIL - 3'd1)) begin
                    state_d = LOCKOUT;
                end else if (auth_state == WAITS) begin
                    state_d = IDLE;
                end else if (t_step) begin
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d = ABORT;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            LOCKOUT: begin
                if (lock_expire) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if (state_q == LOCKOUT) begin
            if (lock_expire) fail_cnt_d = '0;
        end else if (fail_ev) begin
            fail_cnt_d = sat_inc(fail_cnt_q, MAX_FAIL);
        end else if (succ_ev) begin
            fail_cnt_d = '0;
        end
    end

    always_comb begin
        t_step   = 1'b0;
        p_lvl    = 1'b0;
        auth_rst = 1'b0;
        locked   = 1'b0;
        case (state_q)
            IDLE, ACTIVE: begin
                t_step = t_step_q;
                p_lvl  = p_clean;
            end
            LOCKOUT: begin
                locked   = 1'b1;
                auth_rst = (timer_q == '0);
            end
            ABORT: begin
                p_lvl    = p_clean;
                auth_rst = 1'b1;
            end
            default: begin
                t_step = 1'b0;
            end
        endcase
    end

    assign fail_cnt = fail_cnt_q;
    assign ctrl_dbg = state_q;

endmodule

// File: tb/tb_auth_session_ctrl.sv
// tb/tb_auth_session_ctrl.sv - bench for auth_session_ctrl driving a behavioural card FSM
module tb_auth_session_ctrl;

    localparam logic [15:0] DEB   = 16'd4;
    localparam logic [31:0] TOUT  = 32'd20;
    localparam logic [2:0]  MAXF  = 3'd3;
    localparam logic [31:0] LOCKC = 32'd30;

    localparam logic [1:0] C_IDLE = 2'b00, C_ACTIVE = 2'b01, C_LOCKOUT = 2'b10, C_ABORT = 2'b11;
    localparam int STEP_LAT = 2 + int'(DEB) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_t = 1'b0;
    logic       btn_p = 1'b0;
    logic       auth_a, auth_e, auth_f;
    logic [2:0] auth_state;
    logic       t_step, p_lvl, auth_rst, locked;
    logic [2:0] fail_cnt;
    logic [1:0] ctrl_dbg;

    int vectors = 0, miscompares = 0;
    int t_pulses = 0, rst_cycles = 0, lock_cycles = 0, eject_cycles = 0;
    int rst_run = 0, rst_run_max = 0;
    int exp_fc = 0;
    int r0, first, nb, press_at;
    bit ok;

    always #5 clk = ~clk;

    auth_session_ctrl #(
        .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TOUT), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCKC)
    ) dut (
        .clk(clk), .rst(rst), .btn_t(btn_t), .btn_p(btn_p),
        .auth_a(auth_a), .auth_e(auth_e), .auth_f(auth_f), .auth_state(auth_state),
        .t_step(t_step), .p_lvl(p_lvl), .auth_rst(auth_rst), .locked(locked),
        .fail_cnt(fail_cnt), .ctrl_dbg(ctrl_dbg)
    );

    // Card FSM: wait -> card -> pin -> pin ok -> eject, wrong pin -> fail; eject/fail auto-return.
    logic       fsm_rst;
    logic [2:0] fsm_q;
    assign fsm_rst = rst | auth_rst;
    always @(posedge clk or posedge fsm_rst) begin
        if (fsm_rst) fsm_q <= 3'b000;
        else case (fsm_q)
            3'b000:  if (t_step) fsm_q <= 3'b001;
            3'b001:  if (t_step) fsm_q <= 3'b010;
            3'b010:  if (t_step) fsm_q <= p_lvl ? 3'b011 : 3'b101;
            3'b011:  if (t_step) fsm_q <= p_lvl ? 3'b100 : 3'b101;
            default: fsm_q <= 3'b000;
        endcase
    end
    assign auth_state = fsm_q;
    assign auth_a     = (fsm_q == 3'b011) || (fsm_q == 3'b100);
    assign auth_e     = (fsm_q == 3'b100);
    assign auth_f     = (fsm_q == 3'b101);

    always @(negedge clk) begin
        if (t_step) t_pulses++;
        if (locked) lock_cycles++;
        if (auth_state == 3'b100) eject_cycles++;
        if (auth_rst) begin
            rst_cycles++;
            rst_run++;
            if (rst_run > rst_run_max) rst_run_max = rst_run;
        end else begin
            rst_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press_only(input logic p);
        bit seen;
        seen  = 1'b0;
        btn_p = p;
        btn_t = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (t_step) seen = 1'b1;
        end
        btn_t = 1'b0;
        check("step_strobe", 32'(seen), 1);
    endtask

    task automatic step(input logic p);
        press_only(p);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_active(output bit found);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (ctrl_dbg == C_ACTIVE) found = 1'b1;
        end
        check("enter_active", 32'(found), 1);
    endtask

    // Reference: a failed attempt bumps the count (saturating), a success clears it,
    // reaching MAXF locks for LOCKC cycles and then clears it.
    task automatic do_op(input bit success);
        int rs0, e0, t0, l0;
        rs0 = rst_cycles; e0 = eject_cycles; l0 = lock_cycles;
        step(1'b0);
        step(1'b0);
        if (success) begin
            step(1'b1);
            step(1'b1);
        end else begin
            step(1'b0);
        end
        repeat (4) @(negedge clk);
        if (success) exp_fc = 0;
        else if (exp_fc < int'(MAXF)) exp_fc++;
        check("op_eject", 32'(eject_cycles - e0), success ? 1 : 0);
        if (!success && exp_fc == int'(MAXF)) begin
            check("lock_on", 32'(locked), 1);
            check("lock_fail_cnt", 32'(fail_cnt), 32'(MAXF));
            check("lock_state", 32'(ctrl_dbg), 32'(C_LOCKOUT));
            t0 = t_pulses;
            btn_t = 1'b1;
            repeat (8) @(negedge clk);
            btn_t = 1'b0;
            repeat (7) @(negedge clk);
            check("lock_no_step", 32'(t_pulses - t0), 0);
            for (int i = 0; i < 80 && locked; i++) @(negedge clk);
            check("lock_len", 32'(lock_cycles - l0), LOCKC);
            check("lock_rst_pulse", 32'(rst_cycles - rs0), 1);
            check("lock_clear_cnt", 32'(fail_cnt), 0);
            check("lock_exit_idle", 32'(ctrl_dbg), 32'(C_IDLE));
            exp_fc = 0;
        end else begin
            check("op_fail_cnt", 32'(fail_cnt), 32'(exp_fc));
            check("op_idle", 32'(ctrl_dbg), 32'(C_IDLE));
            check("op_no_rst", 32'(rst_cycles - rs0), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_t_step", 32'(t_step), 0);
        check("rst_p_lvl", 32'(p_lvl), 0);
        check("rst_auth_rst", 32'(auth_rst), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_fail_cnt", 32'(fail_cnt), 0);
        check("rst_ctrl", 32'(ctrl_dbg), 32'(C_IDLE));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // bouncing press: alternating single-cycle glitches, then a steady hold
        nb = 2 * int'($urandom_range(1, 3));
        r0 = t_pulses;
        for (int i = 0; i < nb; i++) begin
            btn_t = (i % 2 == 0);
            @(negedge clk);
        end
        btn_t = 1'b1;
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (t_step && first < 0) first = k;
        end
        btn_t = 1'b0;
        check("bounce_latency", 32'(first), 32'(STEP_LAT));
        repeat (40) @(negedge clk);
        check("bounce_pulses", 32'(t_pulses - r0), 1);
        check("bounce_then_idle", 32'(ctrl_dbg), 32'(C_IDLE));

        // inactivity abort from the card state
        r0 = rst_cycles;
        press_only(1'b0);
        wait_active(ok);
        for (int n = 1; n <= int'(TOUT) + 1; n++) begin
            @(negedge clk);
            if (n == int'(TOUT) - 1) check("to_pre_active", 32'(ctrl_dbg), 32'(C_ACTIVE));
            if (n == int'(TOUT)) begin
                check("to_abort_pulse", 32'(auth_rst), 1);
                check("to_abort_state", 32'(ctrl_dbg), 32'(C_ABORT));
            end
            if (n == int'(TOUT) + 1) begin
                check("to_idle", 32'(ctrl_dbg), 32'(C_IDLE));
                check("to_fsm_wait", 32'(auth_state), 0);
                check("to_rst_low", 32'(auth_rst), 0);
                check("to_fail_kept", 32'(fail_cnt), 32'(exp_fc));
            end
        end
        check("to_rst_count", 32'(rst_cycles - r0), 1);

        // step strobe landing on the expiry cycle cancels the abort
        r0 = rst_cycles;
        press_at = int'(TOUT) - 1 - STEP_LAT;
        press_only(1'b0);
        wait_active(ok);
        for (int n = 1; n <= int'(TOUT); n++) begin
            @(negedge clk);
            if (n == press_at) btn_t = 1'b1;
            if (n == int'(TOUT) - 1) check("exp_step_hit", 32'(t_step), 1);
            if (n == int'(TOUT)) begin
                check("exp_stay_active", 32'(ctrl_dbg), 32'(C_ACTIVE));
                check("exp_no_rst", 32'(auth_rst), 0);
                check("exp_fsm_pin", 32'(auth_state), 32'(3'b010));
            end
        end
        btn_t = 1'b0;
        repeat (40) @(negedge clk);
        check("exp_later_idle", 32'(ctrl_dbg), 32'(C_IDLE));
        check("exp_later_abort", 32'(rst_cycles - r0), 1);

        // full success path, then three failures into lockout
        do_op(1'b1);
        do_op(1'b0);
        do_op(1'b0);
        do_op(1'b0);

        for (int i = 0; i < 6; i++) do_op(1'($urandom_range(0, 1)));

        // reset in the middle of a lockout
        while (exp_fc < int'(MAXF) - 1) do_op(1'b0);
        step(1'b0);
        step(1'b0);
        press_only(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (locked) ok = 1'b1;
        end
        check("mid_lock_seen", 32'(ok), 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_fail_cnt", 32'(fail_cnt), 0);
        check("mid_rst_ctrl", 32'(ctrl_dbg), 32'(C_IDLE));
        @(negedge clk);
        rst = 1'b0;
        exp_fc = 0;
        repeat (3) @(negedge clk);

        check("auth_rst_width", 32'(rst_run_max), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
